// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that parses a 16-bit big-endian word-count header
// from a valid/ready byte stream, packs bytes big-endian into 32-bit words and
// writes them to instruction memory from address 0, then releases the core.
// Ports:
//   clock, reset_n                  - clock and async active-low reset
//   in_data/in_valid/in_ready       - byte stream handshake
//   imem_we/imem_addr/imem_wdata    - instruction-memory write port (one strobe per word)
//   cpu_run                         - load complete, core may fetch from PC 0
//   error                           - header count exceeded DEPTH
//   words_loaded                    - words written so far (saturates at header count)
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_COMMIT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0]       DEPTH_L = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       count;
  logic [1:0]        bi;
  logic [23:0]       partial;     // bytes 0..2 of the word being assembled
  logic [ADDR_W-1:0] next_addr;   // address the next completed word goes to
  logic              xfer;
  logic              last_word;
  logic [15:0]       hdr_full;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_run   = 1'b0;
    error     = 1'b0;
    hdr_full  = {count[15:8], in_data};
    // The transfer at bi==3 completes word number words_loaded+1.
    last_word = (bi == 2'd3) && ((16'(words_loaded) + 16'd1) == count);

    case (state)
      S_IDLE:   state_nxt = S_HDR_HI;
      S_HDR_HI: in_ready  = 1'b1;
      S_HDR_LO: in_ready  = 1'b1;
      S_DATA:   in_ready  = 1'b1;
      S_COMMIT: state_nxt = S_DONE;
      S_DONE:   cpu_run   = 1'b1;
      S_ERROR:  error     = 1'b1;
      default:  state_nxt = S_IDLE;
    endcase

    xfer = in_valid && in_ready;

    if (xfer) begin
      case (state)
        S_HDR_HI: state_nxt = S_HDR_LO;
        S_HDR_LO: begin
          if (hdr_full == 16'd0) begin
            state_nxt = S_DONE;
          end else if ({1'b0, hdr_full} > DEPTH_L) begin
            state_nxt = S_ERROR;
          end else begin
            state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (last_word) begin
            state_nxt = S_COMMIT;
          end
        end
        default: ;
      endcase
    end
  end

  // Header capture, byte packing and write port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count        <= 16'd0;
      bi           <= 2'd0;
      partial      <= 24'd0;
      next_addr    <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (xfer) begin
        case (state)
          S_HDR_HI: count[15:8] <= in_data;
          S_HDR_LO: count[7:0]  <= in_data;
          S_DATA: begin
            bi <= bi + 2'd1;
            if (bi != 2'd3) begin
              partial <= {partial[15:0], in_data};
            end else begin
              imem_we    <= 1'b1;
              imem_wdata <= {partial, in_data};
              imem_addr  <= next_addr;
              // May wrap to 0 after DEPTH-1; the FSM leaves DATA on that word.
              next_addr  <= next_addr + ONE_A;
              if (16'(words_loaded) < count) begin
                words_loaded <= words_loaded + ONE_W;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued when stimulus is
// driven and compared by a monitor when imem_we fires.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clock;
  logic              reset_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int wr_cnt = 0;
  int we_cyc[$];
  logic [41:0] sb[$];   // {addr, data}

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard
  always @(negedge clock) begin
    if (reset_n && imem_we) begin
      logic [41:0] exp;
      wr_cnt++;
      we_cyc.push_back(cyc);
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(exp[41:32]));
        check("wr_data", 64'(imem_wdata), 64'(exp[31:0]));
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'hxx;
      @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) check("accept_timeout", 64'(t), 64'd0);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] addr, input logic [31:0] w, input int gap);
    sb.push_back({addr, w});
    send(w[31:24], gap);
    send(w[23:16], gap);
    send(w[15:8],  gap);
    send(w[7:0],   gap);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},  64'(in_ready),     64'd0);
    check({tag, "_we"},   64'(imem_we),      64'd0);
    check({tag, "_addr"}, 64'(imem_addr),    64'd0);
    check({tag, "_wdat"}, 64'(imem_wdata),   64'd0);
    check({tag, "_run"},  64'(cpu_run),      64'd0);
    check({tag, "_err"},  64'(error),        64'd0);
    check({tag, "_wl"},   64'(words_loaded), 64'd0);
  endtask

  task automatic do_reset();
    check("sb_drained", 64'(sb.size()), 64'd0);
    @(negedge clock);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_vals("rst");
    @(negedge clock);
    sb.delete();
    we_cyc.delete();
    wr_cnt  = 0;
    reset_n = 1'b1;
    // IDLE lasts one cycle: no byte accepted at the first edge
    check("idle_rdy", 64'(in_ready), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clock);

    // 1: two-word load at full rate
    do_reset();
    send(8'h00, 0); send(8'h02, 0);
    send_word(10'd0, 32'h34080005, 0);
    send_word(10'd1, 32'h20090003, 0);
    check("t1_commit_run", 64'(cpu_run), 64'd0);
    check("t1_wl_last", 64'(words_loaded), 64'd2);
    @(negedge clock);
    check("t1_run", 64'(cpu_run), 64'd1);
    check("t1_rdy", 64'(in_ready), 64'd0);
    check("t1_wl", 64'(words_loaded), 64'd2);
    check("t1_nwr", 64'(wr_cnt), 64'd2);
    if (we_cyc.size() == 2) check("t1_spacing", 64'(we_cyc[1] - we_cyc[0]), 64'd4);
    else check("t1_we_count", 64'(we_cyc.size()), 64'd2);
    // trailing bytes are not consumed
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(negedge clock);
    check("t1_trail_rdy", 64'(in_ready), 64'd0);
    check("t1_trail_run", 64'(cpu_run), 64'd1);
    in_valid = 1'b0;

    // 2: same stream with valid toggling
    do_reset();
    send(8'h00, 1); send(8'h02, 1);
    send_word(10'd0, 32'h34080005, 1);
    send_word(10'd1, 32'h20090003, 1);
    @(negedge clock);
    check("t2_run", 64'(cpu_run), 64'd1);
    check("t2_nwr", 64'(wr_cnt), 64'd2);
    check("t2_wl", 64'(words_loaded), 64'd2);

    // 3: zero-count header
    do_reset();
    send(8'h00, 0); send(8'h00, 0);
    check("t3_run", 64'(cpu_run), 64'd1);
    check("t3_err", 64'(error), 64'd0);
    check("t3_rdy", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clock);
    check("t3_nwr", 64'(wr_cnt), 64'd0);

    // 4: over-range header 1025
    do_reset();
    send(8'h04, 0); send(8'h01, 0);
    check("t4_err", 64'(error), 64'd1);
    check("t4_run", 64'(cpu_run), 64'd0);
    check("t4_rdy", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clock);
    check("t4_nwr", 64'(wr_cnt), 64'd0);
    check("t4_err_hold", 64'(error), 64'd1);

    // 5: exactly DEPTH words
    do_reset();
    send(8'h04, 0); send(8'h00, 0);
    check("t5_no_err", 64'(error), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      send_word(10'(i), w, 0);
    end
    check("t5_last_addr", 64'(imem_addr), 64'd1023);
    @(negedge clock);
    check("t5_run", 64'(cpu_run), 64'd1);
    check("t5_wl", 64'(words_loaded), 64'd1024);
    check("t5_nwr", 64'(wr_cnt), 64'd1024);

    // 6: reset mid-load, then reload
    do_reset();
    send(8'h00, 0); send(8'h03, 0);
    send_word(10'd0, 32'hDEADBEEF, 0);
    send(8'h11, 0); send(8'h22, 0);
    check("t6_nwr_pre", 64'(wr_cnt), 64'd1);
    check("t6_wl_pre", 64'(words_loaded), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    @(negedge clock);
    wr_cnt  = 0;
    reset_n = 1'b1;
    send(8'h00, 0); send(8'h01, 0);
    send_word(10'd0, 32'hCAFEF00D, 0);
    @(negedge clock);
    check("t6_run", 64'(cpu_run), 64'd1);
    check("t6_nwr", 64'(wr_cnt), 64'd1);
    check("t6_wl", 64'(words_loaded), 64'd1);
    check("t6_sb", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
